window_peak_detector: RTL and testbench

//   Reduces a 12-bit signed sample stream to one 12-bit unsigned peak value per window of

---
 rtl/window_peak_detector_pkg.sv | 19 +
 rtl/window_peak_detector_abs_saturate.sv | 25 ++
 rtl/window_peak_detector.sv | 132 +++++++++++++
 tb/tb_window_peak_detector.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_peak_detector_pkg.sv
// Shared definitions for the window peak detector.
// Holds the sample width, the full-scale codes and the two-state control
// encoding used by the top level.
package window_peak_detector_pkg;

  localparam int unsigned SAMPLE_W = 12;

  // Largest representable magnitude; -2048 saturates to this.
  localparam logic [SAMPLE_W-1:0] PEAK_MAX = 12'd2047;

  localparam logic signed [SAMPLE_W-1:0] FS_POS = 12'sh7FF;
  localparam logic signed [SAMPLE_W-1:0] FS_NEG = 12'sh800;

  typedef enum logic {
    StIdle  = 1'b0,
    StAccum = 1'b1
  } state_e;

endpackage

// File: rtl/window_peak_detector_abs_saturate.sv
// Combinational magnitude of a two's-complement sample.
// Ports:
//   sample_i    - signed sample
//   mag_o       - |sample_i|, with -2048 saturated to 2047 (bit 11 always 0)
//   fullscale_o - sample_i is either full-scale code (2047 or -2048)
module abs_saturate
  import window_peak_detector_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] sample_i,
  output logic        [SAMPLE_W-1:0] mag_o,
  output logic                       fullscale_o
);

  always_comb begin
    fullscale_o = (sample_i == FS_POS) || (sample_i == FS_NEG);
    if (sample_i == FS_NEG) begin
      mag_o = PEAK_MAX;
    end else if (sample_i[SAMPLE_W-1]) begin
      mag_o = ~sample_i + 12'd1;
    end else begin
      mag_o = sample_i;
    end
  end

endmodule

// File: rtl/window_peak_detector.sv
// Per-channel window peak detector.
// Reduces a signed sample stream to one unsigned peak per WINDOW accepted
// samples, with optional decaying peak-hold and a per-window clip flag.
// Ports:
//   data_clk     - clock, rising edge
//   reset_n      - asynchronous active-low reset
//   enable       - run when high; low discards the partial window and hold
//   sample_in    - two's-complement sample, qualified by sample_valid
//   sample_valid - sample qualifier
//   peak_out     - latest window peak, held between pulses
//   peak_valid   - one-cycle pulse when peak_out updates
//   clip_out     - with peak_valid: the window contained a full-scale sample
module window_peak_detector
  import window_peak_detector_pkg::*;
#(
  parameter int unsigned WINDOW = 64,
  parameter int unsigned CNT_W  = 6,
  parameter int unsigned DECAY  = 16
) (
  input  logic                       data_clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic        [SAMPLE_W-1:0] peak_out,
  output logic                       peak_valid,
  output logic                       clip_out
);

  localparam logic [CNT_W-1:0]    LastCnt  = CNT_W'(WINDOW - 1);
  localparam logic [SAMPLE_W-1:0] DecayAmt = SAMPLE_W'(DECAY);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [SAMPLE_W-1:0] acc_q, acc_d;
  logic                clip_acc_q, clip_acc_d;
  logic [SAMPLE_W-1:0] held_q, held_d;
  logic [SAMPLE_W-1:0] peak_q, peak_d;
  logic                valid_q, valid_d;
  logic                clip_q, clip_d;

  logic [SAMPLE_W-1:0] mag;
  logic                fullscale;
  logic [CNT_W-1:0]    win_pos;
  logic [SAMPLE_W-1:0] win_max;
  logic [SAMPLE_W-1:0] decayed;
  logic [SAMPLE_W-1:0] next_peak;

  abs_saturate u_abs_saturate (
    .sample_i    (sample_in),
    .mag_o       (mag),
    .fullscale_o (fullscale)
  );

  // Next-peak datapath: window max including the current sample, and the
  // held value decayed with a floor at zero.
  always_comb begin
    // A window always starts from zero when entering from idle.
    win_pos   = (state_q == StAccum) ? count_q : '0;
    win_max   = (mag > acc_q) ? mag : acc_q;
    decayed   = (held_q > DecayAmt) ? (held_q - DecayAmt) : '0;
    if (DECAY == 0) begin
      next_peak = win_max;
    end else begin
      next_peak = (win_max > decayed) ? win_max : decayed;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    clip_acc_d = clip_acc_q;
    held_d     = held_q;
    peak_d     = peak_q;
    valid_d    = 1'b0;
    clip_d     = 1'b0;

    if (!enable) begin
      // Disable wins over a window-ending sample in the same cycle.
      state_d    = StIdle;
      count_d    = '0;
      acc_d      = '0;
      clip_acc_d = 1'b0;
      held_d     = '0;
    end else begin
      state_d = StAccum;
      if (sample_valid) begin
        if (win_pos == LastCnt) begin
          peak_d     = next_peak;
          held_d     = next_peak;
          clip_d     = clip_acc_q | fullscale;
          valid_d    = 1'b1;
          count_d    = '0;
          acc_d      = '0;
          clip_acc_d = 1'b0;
        end else begin
          count_d    = win_pos + CNT_W'(1);
          acc_d      = win_max;
          clip_acc_d = clip_acc_q | fullscale;
        end
      end
    end
  end

  always_ff @(posedge data_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      acc_q      <= '0;
      clip_acc_q <= 1'b0;
      held_q     <= '0;
      peak_q     <= '0;
      valid_q    <= 1'b0;
      clip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      clip_acc_q <= clip_acc_d;
      held_q     <= held_d;
      peak_q     <= peak_d;
      valid_q    <= valid_d;
      clip_q     <= clip_d;
    end
  end

  assign peak_out   = peak_q;
  assign peak_valid = valid_q;
  assign clip_out   = clip_q;

endmodule

// File: tb/tb_window_peak_detector.sv
// Bench for window_peak_detector. Three instances share one stimulus stream:
//   0: WINDOW=4, DECAY=16   1: WINDOW=4, DECAY=0   2: WINDOW=2, DECAY=0
// A window-buffer model per instance predicts each pulse.
module tb_window_peak_detector;

  localparam int WIN_SZ [3] = '{4, 4, 2};
  localparam int DEC    [3] = '{16, 0, 0};

  logic               clk = 1'b0;
  logic               reset_n;
  logic               enable;
  logic               sample_valid;
  logic signed [11:0] sample_in;
  logic [11:0]        peak_out   [3];
  logic               peak_valid [3];
  logic               clip_out   [3];

  always #5 clk = ~clk;

  window_peak_detector #(.WINDOW(4), .CNT_W(2), .DECAY(16)) u_d16 (
    .data_clk     (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .peak_out     (peak_out[0]),
    .peak_valid   (peak_valid[0]),
    .clip_out     (clip_out[0])
  );

  window_peak_detector #(.WINDOW(4), .CNT_W(2), .DECAY(0)) u_d0 (
    .data_clk     (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .peak_out     (peak_out[1]),
    .peak_valid   (peak_valid[1]),
    .clip_out     (clip_out[1])
  );

  window_peak_detector #(.WINDOW(2), .CNT_W(1), .DECAY(0)) u_w2 (
    .data_clk     (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .peak_out     (peak_out[2]),
    .peak_valid   (peak_valid[2]),
    .clip_out     (clip_out[2])
  );

  // Reference model state
  int win_buf [3][4];
  int win_len [3];
  int held    [3];
  int exp_peak[3];
  bit exp_valid[3];
  bit exp_clip [3];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int mag(int x);
    if (x == -2048) return 2047;
    return (x < 0) ? -x : x;
  endfunction

  function automatic int rand_sample();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return -2048;
    if (r == 1) return 2047;
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      win_len[d]   = 0;
      held[d]      = 0;
      exp_peak[d]  = 0;
      exp_valid[d] = 1'b0;
      exp_clip[d]  = 1'b0;
    end
  endtask

  // One clock edge of the behavioural model: collect accepted samples and
  // reduce the whole window when it fills.
  task automatic model_edge(bit en, bit v, int x);
    int w;
    int dd;
    int n;
    bit c;
    for (int d = 0; d < 3; d++) begin
      exp_valid[d] = 1'b0;
      exp_clip[d]  = 1'b0;
      if (!en) begin
        win_len[d] = 0;
        held[d]    = 0;
      end else if (v) begin
        win_buf[d][win_len[d]] = x;
        win_len[d]++;
        if (win_len[d] == WIN_SZ[d]) begin
          w = 0;
          c = 1'b0;
          for (int i = 0; i < WIN_SZ[d]; i++) begin
            if (mag(win_buf[d][i]) > w) w = mag(win_buf[d][i]);
            if (win_buf[d][i] == 2047 || win_buf[d][i] == -2048) c = 1'b1;
          end
          n = w;
          if (DEC[d] != 0) begin
            dd = held[d] - DEC[d];
            if (dd < 0) dd = 0;
            if (dd > n) n = dd;
          end
          held[d]      = n;
          exp_peak[d]  = n;
          exp_valid[d] = 1'b1;
          exp_clip[d]  = c;
          win_len[d]   = 0;
        end
      end
    end
  endtask

  task automatic step(bit en, bit v, int x);
    enable       = en;
    sample_valid = v;
    sample_in    = 12'(x);
    @(posedge clk);
    #1;
    model_edge(en, v, x);
  endtask

  task automatic apply_reset();
    reset_n      = 1'b0;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (peak_out[d] !== 12'd0 || peak_valid[d] !== 1'b0 || clip_out[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got peak=%0d valid=%b clip=%b, want 0/0/0", d,
                 peak_out[d], peak_valid[d], clip_out[d]);
      end
    end
    step(1, 1, 500);
    step(1, 1, 3);
    // Asynchronous assertion between edges, instance 2 has just pulsed 500.
    #2 reset_n = 1'b0;
    #1;
    model_clear();
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (peak_out[d] !== 12'd0 || peak_valid[d] !== 1'b0 || clip_out[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_async[%0d]: got peak=%0d valid=%b clip=%b, want 0/0/0", d,
                 peak_out[d], peak_valid[d], clip_out[d]);
      end
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1, 1, i);
      n_tests++;
      if (peak_valid[0] !== (i == 4)) begin
        n_fail++;
        $display("FAIL reset_pulse_timing: sample %0d valid=%b want %b", i, peak_valid[0],
                 (i == 4));
      end
    end
    n_tests++;
    if (peak_out[0] !== 12'd4) begin
      n_fail++;
      $display("FAIL reset_first_peak: got %0d want 4", peak_out[0]);
    end
    step(1, 0, 0);
    n_tests++;
    if (peak_valid[0] !== 1'b0 || peak_out[0] !== 12'd4) begin
      n_fail++;
      $display("FAIL reset_pulse_width: valid=%b peak=%0d want 0/4", peak_valid[0],
               peak_out[0]);
    end
  endtask

  task automatic test_mag_clip();
    int s1 [4] = '{-2048, 5, -7, 0};
    int s2 [4] = '{100, -300, 20, 0};
    apply_reset();
    for (int i = 0; i < 4; i++) step(1, 1, s1[i]);
    n_tests++;
    if (peak_valid[1] !== 1'b1 || peak_out[1] !== 12'd2047 || clip_out[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL mag_neg_fullscale: got valid=%b peak=%0d clip=%b want 1/2047/1",
               peak_valid[1], peak_out[1], clip_out[1]);
    end
    step(1, 0, 0);
    n_tests++;
    if (clip_out[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL clip_idle: got clip=%b want 0", clip_out[1]);
    end
    for (int i = 0; i < 4; i++) step(1, 1, s2[i]);
    n_tests++;
    if (peak_valid[1] !== 1'b1 || peak_out[1] !== 12'd300 || clip_out[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL mag_negative: got valid=%b peak=%0d clip=%b want 1/300/0",
               peak_valid[1], peak_out[1], clip_out[1]);
    end
  endtask

  task automatic test_decay();
    int firsts [3] = '{1000, 10, 990};
    int wants  [3] = '{1000, 984, 990};
    int e;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      step(1, 1, firsts[k]);
      for (int i = 0; i < 3; i++) step(1, 1, 0);
      n_tests++;
      if (peak_valid[0] !== 1'b1 || peak_out[0] !== 12'(wants[k])) begin
        n_fail++;
        $display("FAIL decay_window%0d: got valid=%b peak=%0d want 1/%0d", k + 1,
                 peak_valid[0], peak_out[0], wants[k]);
      end
    end
    for (int k = 1; k <= 66; k++) begin
      for (int i = 0; i < 4; i++) step(1, 1, 0);
      e = 990 - 16 * k;
      if (e < 0) e = 0;
      n_tests++;
      if (peak_valid[0] !== 1'b1 || peak_out[0] !== 12'(e)) begin
        n_fail++;
        $display("FAIL decay_floor k=%0d: got valid=%b peak=%0d want 1/%0d", k,
                 peak_valid[0], peak_out[0], e);
      end
    end
  endtask

  task automatic test_throughput();
    int idx;
    int pulses;
    int cycles;
    bit v;
    apply_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1, 1, i);
      n_tests++;
      if (peak_valid[0] !== (i % 4 == 0) ||
          (peak_valid[0] === 1'b1 && peak_out[0] !== 12'(i))) begin
        n_fail++;
        $display("FAIL throughput_ramp i=%0d: got valid=%b peak=%0d want %b/%0d", i,
                 peak_valid[0], peak_out[0], (i % 4 == 0), i);
      end
    end
    apply_reset();
    idx    = 1;
    pulses = 0;
    cycles = 0;
    while (idx <= 16 && cycles < 200) begin
      v = ($urandom_range(0, 2) != 0);
      step(1, v, v ? idx : 0);
      if (v) idx++;
      cycles++;
      if (peak_valid[0] === 1'b1) begin
        pulses++;
        n_tests++;
        if (peak_out[0] !== 12'(4 * pulses)) begin
          n_fail++;
          $display("FAIL stall_ramp pulse %0d: got %0d want %0d", pulses, peak_out[0],
                   4 * pulses);
        end
      end
    end
    n_tests++;
    if (pulses != 4 || idx != 17) begin
      n_fail++;
      $display("FAIL stall_count: got %0d pulses (%0d samples) want 4 (17)", pulses, idx);
    end
  endtask

  task automatic test_enable();
    apply_reset();
    step(1, 1, 900);
    step(1, 1, 5);
    step(0, 0, 0);
    n_tests++;
    if (peak_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_drop_pulse: got valid=%b want 0", peak_valid[0]);
    end
    for (int i = 0; i < 4; i++) step(1, 1, 1);
    n_tests++;
    if (peak_valid[0] !== 1'b1 || peak_out[0] !== 12'd1) begin
      n_fail++;
      $display("FAIL enable_no_carry: got valid=%b peak=%0d want 1/1", peak_valid[0],
               peak_out[0]);
    end
    for (int i = 0; i < 3; i++) step(1, 1, 7);
    step(0, 1, 7);
    n_tests++;
    if (peak_valid[0] !== 1'b0 || peak_out[0] !== 12'd1) begin
      n_fail++;
      $display("FAIL enable_low_on_last: got valid=%b peak=%0d want 0/1", peak_valid[0],
               peak_out[0]);
    end
    // A disable must also drop the hold: 500 would otherwise decay to 484.
    step(1, 1, 500);
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    step(0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    n_tests++;
    if (peak_valid[0] !== 1'b1 || peak_out[0] !== 12'd0) begin
      n_fail++;
      $display("FAIL enable_hold_clear: got valid=%b peak=%0d want 1/0", peak_valid[0],
               peak_out[0]);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      step(1, 1, rand_sample());
      n_tests++;
      if (peak_valid[2] !== (i % 2 == 1) || peak_out[2] !== 12'(exp_peak[2]) ||
          clip_out[2] !== exp_clip[2]) begin
        n_fail++;
        $display("FAIL back_to_back i=%0d: got v=%b p=%0d c=%b want v=%b p=%0d c=%b", i,
                 peak_valid[2], peak_out[2], clip_out[2], (i % 2 == 1), exp_peak[2],
                 exp_clip[2]);
      end
    end
  endtask

  task automatic test_random();
    bit en;
    bit v;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 19) != 0);
      v  = ($urandom_range(0, 3) != 0);
      step(en, v, rand_sample());
      for (int d = 0; d < 3; d++) begin
        n_tests++;
        if (peak_valid[d] !== exp_valid[d] || peak_out[d] !== 12'(exp_peak[d]) ||
            clip_out[d] !== exp_clip[d]) begin
          n_fail++;
          $display("FAIL random[%0d] cyc %0d: got v=%b p=%0d c=%b want v=%b p=%0d c=%b", d,
                   i, peak_valid[d], peak_out[d], clip_out[d], exp_valid[d], exp_peak[d],
                   exp_clip[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mag_clip();
    test_decay();
    test_throughput();
    test_enable();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
